// File: rtl/negedge_retime.sv
`default_nettype none
// ============================================================================
// Module   : negedge_retime
// Brief    : Single-bit flop clocked on the falling edge of clk. It delays a
//            rising-edge signal by half a cycle for odd-ratio duty correction.
// Revision : 1.0 - initial release
// ============================================================================
module negedge_retime (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic r_q;

    // No reset: the upstream phase flop is already reset, and r_q follows it
    // at the next falling edge.
    always_ff @(negedge clk) begin
        r_q <= d;
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/frequency_divider_n.sv
`default_nettype none
// ============================================================================
// Module   : frequency_divider_n
// Brief    : Integer clock divider that produces a 50% duty-cycle clk_out at
//            f_clk / N for both even and odd N.
// Revision : 1.0 - initial release
// ============================================================================
module frequency_divider_n #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out
);

    localparam int              c_half    = N / 2;
    localparam int              c_cnt_w   = (N > 2) ? $clog2(N) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(N - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_set = c_cnt_w'(c_half - 1);

    if (N < 2) begin : g_bad_n
        $error("frequency_divider_n: N must be at least 2");
    end

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_p_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_max) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The phase flop is high for N-H cycles and low for H cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_q <= 1'b0;
        end else if (r_cnt == c_cnt_max) begin
            r_p_q <= 1'b0;
        end else if (r_cnt == c_cnt_set) begin
            r_p_q <= 1'b1;
        end
    end

    if ((N % 2) == 0) begin : g_even
        assign clk_out = r_p_q;
    end else begin : g_odd
        logic w_n_q;

        // Delaying the rise by half a cycle trims the high phase from
        // (N+1)/2 cycles down to N/2 cycles.
        negedge_retime u_negedge_retime (
            .clk (clk),
            .d   (r_p_q),
            .q   (w_n_q)
        );

        assign clk_out = r_p_q & w_n_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_frequency_divider_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_frequency_divider_n
// Brief    : Directed bench for frequency_divider_n at N = 2, 3, 4 and 5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frequency_divider_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic w_out2;
    logic w_out3;
    logic w_out4;
    logic w_out5;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #10 clk = ~clk;

    frequency_divider_n #(.N(2)) u_div2 (.clk(clk), .rst(rst), .clk_out(w_out2));
    frequency_divider_n #(.N(3)) u_div3 (.clk(clk), .rst(rst), .clk_out(w_out3));
    frequency_divider_n #(.N(4)) u_div4 (.clk(clk), .rst(rst), .clk_out(w_out4));
    frequency_divider_n #(.N(5)) u_div5 (.clk(clk), .rst(rst), .clk_out(w_out5));

    task automatic check(input string tag, input int idx, input logic got, input logic exp);
        n_compared++;
        assert (got === exp) else begin
            n_mismatched++;
            $error("FAIL %s[%0d] at %0t: observed=%b expected=%b", tag, idx, $time, got, exp);
        end
    endtask

    // Sample i is taken at 15 + 10*i ns; bit i holds the expected clk_out.
    logic [39:0] c_exp2 = 40'hCCCCCCCCCC;
    logic [39:0] c_exp3 = 40'h8E38E38E38;
    logic [39:0] c_exp4 = 40'hF0F0F0F0F0;
    logic [39:0] c_exp5 = 40'hF83E0F83E0;

    // Sample j is taken at 475 + 10*j ns, reset high at the 470 and 490 edges.
    logic [9:0] c_rexp2 = 10'b1100110000;
    logic [9:0] c_rexp3 = 10'b0011100000;
    logic [9:0] c_rexp4 = 10'b1111000000;
    logic [9:0] c_rexp5 = 10'b1110000000;

    initial begin
        #15;
        check("n2_reset", 0, w_out2, c_exp2[0]);
        check("n3_reset", 0, w_out3, c_exp3[0]);
        check("n4_reset", 0, w_out4, c_exp4[0]);
        check("n5_reset", 0, w_out5, c_exp5[0]);
        #5 rst = 1'b0;
        #5;
        for (int i = 1; i < 40; i++) begin
            check("n2_run", i, w_out2, c_exp2[i]);
            check("n3_run", i, w_out3, c_exp3[i]);
            check("n4_run", i, w_out4, c_exp4[i]);
            check("n5_run", i, w_out5, c_exp5[i]);
            #10;
        end

        // t = 415: wait into the N=4 high phase that starts at 450 ns.
        #50;
        check("n4_pre_rst_high", 0, w_out4, 1'b1);
        #1 rst = 1'b1;
        #9;
        for (int j = 0; j < 10; j++) begin
            check("n2_rst", j, w_out2, c_rexp2[j]);
            check("n3_rst", j, w_out3, c_rexp3[j]);
            check("n4_rst", j, w_out4, c_rexp4[j]);
            check("n5_rst", j, w_out5, c_rexp5[j]);
            if (j == 2) rst = 1'b0;
            #10;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
